// File: rtl/macarray_pkg.sv
// Shared types and constants for the OUT_MEM read side of the MAC array:
// memory geometry, MNT field extraction, and the reader FSM state encoding.
package macarray_pkg;

    localparam int DW     = 16;          // element width
    localparam int BW     = 64;          // SRAM word width
    localparam int AW     = 4;           // SRAM address width
    localparam int LANES  = BW / DW;     // elements per word
    localparam int LANE_W = $clog2(LANES);
    localparam int MAXD   = 8;           // max M/T, column-group stride

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WT   = 3'd2,
        S_EMIT = 3'd3,
        S_FIN  = 3'd4
    } outrd_state_t;

    function automatic logic [3:0] mnt_m(input logic [11:0] mnt);
        return mnt[11:8];
    endfunction

    function automatic logic [3:0] mnt_n(input logic [11:0] mnt);
        return mnt[7:4];
    endfunction

    function automatic logic [3:0] mnt_t(input logic [11:0] mnt);
        return mnt[3:0];
    endfunction

    // Word holding row t of column group g.
    function automatic logic [AW-1:0] word_addr(input logic g, input logic [2:0] t);
        int a;
        a = int'(g) * MAXD + int'(t);
        return a[AW-1:0];
    endfunction

endpackage

// File: rtl/outrd_lane_sel.sv
// Combinational lane extract: returns element `lane_i` of a packed word,
// with lane 0 held in the most significant DW bits.
module outrd_lane_sel
    import macarray_pkg::*;
(
    input  logic [BW-1:0]     word_i,
    input  logic [LANE_W-1:0] lane_i,
    output logic [DW-1:0]     lane_o
);

    // MSB-first lane mux.
    always_comb begin
        lane_o = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_i == LANE_W'(i)) lane_o = word_i[(LANES-1-i)*DW +: DW];
        end
    end

endmodule

// File: rtl/outmem_reader.sv
// OUT_MEM reader: walks the T x M result matrix row-major, reads each packed
// word once and streams its lanes one element per cycle on a valid/ready port.
// Optional feature: define OUTRD_PAD_CHECK_EN to add the PAD_ERR output, which
// flags nonzero padding lanes in words that are read.
//
// Stream handshake: an element transfers on a rising CLK edge where OUT_VALID
// and OUT_READY are both high; while OUT_VALID is high and OUT_READY is low,
// OUT_DATA/OUT_ROW/OUT_COL/OUT_LAST hold their values.
module outmem_reader
    import macarray_pkg::*;
(
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START,
    input  logic [11:0]   MNT,
    output logic          EN_O,
    output logic [AW-1:0] ADDR_O,
    input  logic [BW-1:0] RDATA_O,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_DATA,
    output logic [2:0]    OUT_ROW,
    output logic [2:0]    OUT_COL,
    output logic          OUT_LAST,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
`ifdef OUTRD_PAD_CHECK_EN
    output logic          PAD_ERR,
`endif
    output outrd_state_t  DBG_STATE
);

    outrd_state_t        state_q, state_d;
    logic                start_q, start_d;
    logic                armed_q, armed_d;
    logic [3:0]          m_q, m_d;
    logic [3:0]          tn_q, tn_d;
    logic [2:0]          t_q, t_d;
    logic                g_q, g_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [BW-1:0]       buf_q, buf_d;
    logic                en_q, en_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                valid_q, valid_d;
    logic [DW-1:0]       data_q, data_d;
    logic [2:0]          row_q, row_d;
    logic [2:0]          col_q, col_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [3:0]          m_minus1, rem;
    logic                last_g, final_group, final_row;
    logic [LANE_W-1:0]   last_lane, lane_nxt;
    logic [BW-1:0]       sel_word;
    logic [DW-1:0]       sel_data;
    logic                start_rise, illegal;
    logic [3:0]          unused_n;

    // N is carried in MNT but has no role on the read side.
    assign unused_n = mnt_n(MNT);

    // A START held high through reset release must not count as a new edge,
    // so an edge is only accepted once START has been seen low after reset.
    assign start_rise = START & ~start_q & armed_q;
    assign illegal    = (mnt_m(MNT) == 4'd0) || (mnt_m(MNT) > 4'(MAXD)) ||
                        (mnt_t(MNT) == 4'd0) || (mnt_t(MNT) > 4'(MAXD));

    // Walk bookkeeping: last group of the row, last lane of the current word.
    assign m_minus1    = m_q - 4'd1;
    assign last_g      = m_minus1[2];
    assign rem         = m_minus1 - {1'b0, g_q, 2'b00};
    assign last_lane   = (rem >= 4'd3) ? 2'd3 : rem[1:0];
    assign final_group = (g_q == last_g);
    assign final_row   = ({1'b0, t_q} == (tn_q - 4'd1));

    // The lane about to be presented comes straight from RDATA_O when leaving
    // WT, otherwise from the buffered word.
    assign lane_nxt = (state_q == S_WT) ? '0 : lane_q + 1'b1;
    assign sel_word = (state_q == S_WT) ? RDATA_O : buf_q;

    outrd_lane_sel u_lane_sel (
        .word_i (sel_word),
        .lane_i (lane_nxt),
        .lane_o (sel_data)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        start_d = START;
        armed_d = armed_q | ~START;
        m_d     = m_q;
        tn_d    = tn_q;
        t_d     = t_q;
        g_d     = g_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        en_d    = en_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        data_d  = data_q;
        row_d   = row_q;
        col_d   = col_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    m_d  = mnt_m(MNT);
                    tn_d = mnt_t(MNT);
                    if (illegal) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        err_d   = 1'b0;
                        t_d     = '0;
                        g_d     = 1'b0;
                        en_d    = 1'b1;
                        addr_d  = word_addr(1'b0, 3'd0);
                        busy_d  = 1'b1;
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                en_d    = 1'b0;
                state_d = S_WT;
            end
            S_WT: begin
                buf_d   = RDATA_O;
                lane_d  = '0;
                valid_d = 1'b1;
                data_d  = sel_data;
                row_d   = t_q;
                col_d   = {g_q, 2'b00};
                last_d  = final_row && final_group && (last_lane == '0);
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (OUT_READY) begin
                    if (lane_q != last_lane) begin
                        lane_d = lane_nxt;
                        data_d = sel_data;
                        col_d  = {g_q, lane_nxt};
                        last_d = final_row && final_group && (lane_nxt == last_lane);
                    end else if (final_row && final_group) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        en_d    = 1'b1;
                        state_d = S_RD;
                        if (final_group) begin
                            g_d    = 1'b0;
                            t_d    = t_q + 3'd1;
                            addr_d = word_addr(1'b0, t_q + 3'd1);
                        end else begin
                            g_d    = g_q + 1'b1;
                            addr_d = word_addr(g_q + 1'b1, t_q);
                        end
                    end
                end
            end
            S_FIN: begin
                // A normal run arrives with DONE already raised; an error run
                // spends one settle cycle here first so its DONE lands two
                // cycles after the START edge.
                if (done_q) state_d = S_IDLE;
                else        done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any run without a DONE.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            armed_q <= 1'b0;
            m_q     <= '0;
            tn_q    <= '0;
            t_q     <= '0;
            g_q     <= 1'b0;
            lane_q  <= '0;
            buf_q   <= '0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            armed_q <= armed_d;
            m_q     <= m_d;
            tn_q    <= tn_d;
            t_q     <= t_d;
            g_q     <= g_d;
            lane_q  <= lane_d;
            buf_q   <= buf_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            row_q   <= row_d;
            col_q   <= col_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef OUTRD_PAD_CHECK_EN
    logic [LANES-1:0] pad_hit;
    logic             pad_err_q, pad_err_d;

    for (genvar i = 0; i < LANES; i++) begin : g_pad
        logic [DW-1:0] lane_val;
        outrd_lane_sel u_pad_sel (
            .word_i (RDATA_O),
            .lane_i (LANE_W'(i)),
            .lane_o (lane_val)
        );
        assign pad_hit[i] = ({1'b0, g_q, LANE_W'(i)} >= m_q) && (lane_val != '0);
    end

    // Sticky flag for nonzero padding lanes seen while a word is captured.
    always_comb begin
        pad_err_d = pad_err_q;
        if ((state_q == S_IDLE) && start_rise) pad_err_d = 1'b0;
        else if ((state_q == S_WT) && (|pad_hit)) pad_err_d = 1'b1;
    end

    // Padding-error flag register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) pad_err_q <= 1'b0;
        else       pad_err_q <= pad_err_d;
    end

    assign PAD_ERR = pad_err_q;
`endif

    assign EN_O      = en_q;
    assign ADDR_O    = addr_q;
    assign OUT_VALID = valid_q;
    assign OUT_DATA  = data_q;
    assign OUT_ROW   = row_q;
    assign OUT_COL   = col_q;
    assign OUT_LAST  = last_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_outmem_reader.sv
// Bench for outmem_reader: SRAM model, element and read-address scoreboards,
// run task with latency checks, reset-abort and error-run scenarios.
module tb_outmem_reader;
    import macarray_pkg::*;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [11:0]   mnt;
    logic          en_o;
    logic [AW-1:0] addr_o;
    logic [BW-1:0] rdata = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    out_row;
    logic [2:0]    out_col;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;
`ifdef OUTRD_PAD_CHECK_EN
    logic          pad_err;
`endif
    outrd_state_t  dbg_state;

    logic [BW-1:0] mem [16];
    logic [22:0]   exp_q[$];     // {last, row, col, data}
    logic [AW-1:0] exp_a_q[$];   // expected SRAM read addresses

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0, valid_cnt = 0, done_cnt = 0;
    int first_en = -1, first_valid = -1, last_hs = -1, done_cyc = -1;
    int start_cyc = 0;

    outmem_reader dut (
        .CLK       (clk),
        .RSTN      (rstn),
        .START     (start),
        .MNT       (mnt),
        .EN_O      (en_o),
        .ADDR_O    (addr_o),
        .RDATA_O   (rdata),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_DATA  (out_data),
        .OUT_ROW   (out_row),
        .OUT_COL   (out_col),
        .OUT_LAST  (out_last),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err),
`ifdef OUTRD_PAD_CHECK_EN
        .PAD_ERR   (pad_err),
`endif
        .DBG_STATE (dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read SRAM: data valid the cycle after EN_O is sampled.
    always @(posedge clk) if (en_o) rdata <= mem[addr_o];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor on the falling edge: reads, stream elements, DONE pulses.
    always @(negedge clk) begin
        if (en_o) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            check_eq("rd_expected", exp_a_q.size() != 0, 1'b1);
            if (exp_a_q.size() != 0) begin
                check_eq("rd_addr", addr_o, exp_a_q[0]);
                void'(exp_a_q.pop_front());
            end
        end
        if (out_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
            check_eq("elem_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                check_eq("elem", {out_last, out_row, out_col, out_data}, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    last_hs = cyc;
                end
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // mode 0: ramp, 1: random, 2: ramp with zero padding lanes for M=m.
    task automatic fill_mem(input int mode, input int m);
        logic [DW-1:0] v;
        for (int a = 0; a < 16; a++) begin
            for (int l = 0; l < LANES; l++) begin
                case (mode)
                    0:       v = DW'(a * 16 + l + 1);
                    1:       v = DW'($urandom_range(0, 65535));
                    default: v = (((a / MAXD) * LANES + l) >= m) ? '0 : DW'(a * 16 + l + 1);
                endcase
                mem[a][(LANES-1-l)*DW +: DW] = v;
            end
        end
    endtask

    // Expected reads and elements for a legal run, in row-major order.
    task automatic build_exp(input logic [11:0] cfg);
        int m, t, a, c;
        logic [DW-1:0] d;
        m = int'(cfg[11:8]);
        t = int'(cfg[3:0]);
        for (int r = 0; r < t; r++) begin
            for (int g = 0; g * LANES < m; g++) begin
                a = g * MAXD + r;
                exp_a_q.push_back(AW'(a));
                for (int l = 0; l < LANES && g * LANES + l < m; l++) begin
                    c = g * LANES + l;
                    d = mem[a][(LANES-1-l)*DW +: DW];
                    exp_q.push_back({(r == t - 1 && c == m - 1), 3'(r), 3'(c), d});
                end
            end
        end
    endtask

    task automatic run(input logic [11:0] cfg, input bit toggle, input int span);
        int m, t, d0, e0, v0, n_rd;
        bit legal;
        m = int'(cfg[11:8]);
        t = int'(cfg[3:0]);
        legal = (m >= 1 && m <= MAXD && t >= 1 && t <= MAXD);
        if (legal) build_exp(cfg);
        n_rd = legal ? t * ((m + LANES - 1) / LANES) : 0;
        d0 = done_cnt;
        e0 = en_cnt;
        v0 = valid_cnt;
        first_en = -1;
        first_valid = -1;
        last_hs = -1;
        @(posedge clk); #1;
        mnt = cfg;
        start = 1'b1;
        start_cyc = cyc;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
            @(posedge clk); #1;
            out_ready = toggle ? ~out_ready : 1'b1;
        end
        check_eq("done_seen", done_cnt != d0, 1'b1);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("done_once", done_cnt - d0, 1);
        check_eq("elems_left", exp_q.size(), 0);
        check_eq("reads_left", exp_a_q.size(), 0);
        check_eq("read_count", en_cnt - e0, n_rd);
        check_eq("busy_idle", busy, 1'b0);
        check_eq("err_flag", err, !legal);
        if (legal) begin
            check_eq("en_latency", first_en - start_cyc, 1);
            check_eq("valid_latency", first_valid - start_cyc, 3);
            check_eq("done_after_last", done_cyc - last_hs, 1);
        end else begin
            check_eq("err_done_latency", done_cyc - start_cyc, 2);
            check_eq("err_no_valid", valid_cnt - v0, 0);
        end
        if (span > 0) check_eq("span", last_hs - first_en + 1, span);
        exp_q.delete();
        exp_a_q.delete();
    endtask

    initial begin
        int e0, d0;
        rstn = 1'b0;
        start = 1'b0;
        mnt = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", {en_o, addr_o, out_valid, out_data, out_row, out_col,
                                out_last, busy, done, err}, '0);
        check_eq("reset_state", dbg_state, S_IDLE);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        fill_mem(1, 0);
        run(12'h666, 1'b0, 60);
        fill_mem(0, 0);
        run(12'h888, 1'b0, 96);
        fill_mem(1, 0);
        run(12'h363, 1'b1, 0);
        run(12'h066, 1'b0, 0);
        run(12'h988, 1'b0, 0);
        run(12'h880, 1'b0, 0);
        run(12'h101, 1'b0, 0);
        run(12'h525, 1'b1, 0);

        // Reset in the middle of streaming a full 8x8 run.
        fill_mem(1, 0);
        build_exp(12'h888);
        @(posedge clk); #1;
        mnt = 12'h888;
        start = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        d0 = done_cnt;
        rstn = 1'b0;
        #1;
        check_eq("abort_outs", {en_o, addr_o, out_valid, out_data, out_row, out_col,
                                out_last, busy, done, err}, '0);
        check_eq("abort_state", dbg_state, S_IDLE);
        exp_q.delete();
        exp_a_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        e0 = en_cnt;
        repeat (10) @(posedge clk);
        #1;
        check_eq("no_restart_rd", en_cnt - e0, 0);
        check_eq("no_restart_busy", busy, 1'b0);
        check_eq("no_done_on_abort", done_cnt - d0, 0);
        start = 1'b0;
        @(posedge clk);
        run(12'h888, 1'b0, 96);

`ifdef OUTRD_PAD_CHECK_EN
        fill_mem(2, 5);
        run(12'h555, 1'b0, 0);
        check_eq("pad_clean", pad_err, 1'b0);
        mem[8][(LANES-2)*DW +: DW] = 16'hbeef;
        run(12'h555, 1'b0, 0);
        check_eq("pad_dirty", pad_err, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case a run never completes.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/outmem_reader.md
# outmem_reader

Drains the 64-bit output SRAM after `macarray` finishes a T×M product. It walks the T×M result matrix in row-major order and fetches each packed word once. It unpacks the four 16-bit lanes and presents one element per cycle on a valid/ready stream. It sits on the read side of OUT_MEM, opposite `macarray`'s write port, and feeds result checking and export logic.

## Interface
- `DW`, 16, element width in bits
- `BW`, 64, SRAM word width; lanes = BW/DW = 4
- `AW`, 4, SRAM address width
- `MAXD`, 8, maximum M/T; column-group address stride
- `CLK` in 1 — single clock, rising edge
- `RSTN` in 1 — reset, asynchronous, active-low
- `START` in 1 — run request; rising edge detected internally
- `MNT` in 12 — M=[11:8], N=[7:4] (ignored), T=[3:0]; sampled on accepted START
- `EN_O` out 1 — SRAM chip enable (read only; drives CSN=~EN_O, WEN=1)
- `ADDR_O` out AW — SRAM word address
- `RDATA_O` in BW — SRAM read data, valid the cycle after EN_O is sampled
- `OUT_VALID` out 1 — element valid
- `OUT_READY` in 1 — consumer accepts
- `OUT_DATA` out DW — element value
- `OUT_ROW`, `OUT_COL` out 3 each — zero-based t, m of element
- `OUT_LAST` out 1 — final element of run
- `BUSY` out 1 — run in progress
- `DONE` out 1 — one-cycle pulse at run end
- `ERR` out 1 — sticky; illegal M or T at START; cleared by next accepted START

## Operation
- Address map: element (t,m) is in word `(m>>2)*MAXD + t`. Lane `m%4` is held MSB-first: lane 0 = [63:48], lane 3 = [15:0].
- FSM: IDLE → RD → WT → EMIT → (RD | FIN) → IDLE.
  - IDLE: on START rising edge (registered START_q, reset 0), latch M and T.
    - If M or T is 0 or >8: set ERR, go to FIN with no reads.
    - Otherwise clear ERR, set t=0 and g=0 (column group), go to RD.
  - RD: EN_O=1, ADDR_O=g*8+t for exactly one cycle, then go to WT.
  - WT: EN_O=0; RDATA_O is captured into the word buffer at the end of this cycle. Go to EMIT with lane=0.
  - EMIT: OUT_VALID=1, OUT_DATA = buffer lane, OUT_ROW=t, OUT_COL=4g+lane.
    - On handshake, advance lane.
    - The last lane of a word is min(3, M-1-4g). After it, advance g. When g exceeds the last group (M-1)>>2, reset g=0 and advance t.
    - If t = T-1 and this is the final group, the element is OUT_LAST and the next state is FIN. Otherwise go to RD.
  - FIN: DONE=1 for one cycle, BUSY=0, go to IDLE.
- START edges while not IDLE are ignored. A new run requires START to go low and then high again.
- Rows ≥T and padding lanes are never emitted.
- Reset mid-run aborts immediately: all state returns to IDLE and no DONE is generated.

## Timing
- Reset values: EN_O=0, ADDR_O=0, OUT_VALID=0, OUT_DATA=0, OUT_ROW=0, OUT_COL=0, OUT_LAST=0, BUSY=0, DONE=0, ERR=0. All outputs are registered.
- START high sampled at edge k: EN_O=1 and BUSY=1 in cycle k+1, first OUT_VALID in cycle k+3.
- Per word with OUT_READY=1: 2 + (lanes emitted) cycles.
  - M=T=6: 60 cycles from RD entry to the last handshake.
  - M=T=8: 96 cycles.
- OUT_VALID stays high and OUT_DATA/ROW/COL/LAST stay stable while OUT_READY=0.
- DONE is asserted the cycle after the OUT_LAST handshake. For an ERR run, DONE is asserted 2 cycles after the START edge.

## Configuration
- `OUTRD_PAD_CHECK_EN` defined: during WT, every lane with 4g+lane ≥ M is compared to zero. Any nonzero lane sets sticky output `PAD_ERR` (1 bit, reset 0, cleared on accepted START).
- Not defined: the `PAD_ERR` port and its logic are absent.

## Structure
- Package `macarray_pkg`:
  - DW, BW, AW, LANES, MAXD
  - The MNT field-extract functions
  - FSM state enum `outrd_state_t`
- Sub-module `outrd_lane_sel`: combinational lane extract (word, lane → DW). Also used by the pad check.

## Test plan
- Reset, then START=1 with MNT=12'h666 and OUT_READY=1 → 36 elements in row-major order. Rows 0..5 read addresses 0,8,1,9,…,5,13. DONE fires once. ADDR_O never reaches 6, 7, 14 or 15.
- MNT=12'h888 with a known ramp in OUT_MEM → 64 elements; OUT_LAST on (7,7); 16 SRAM reads; last handshake 96 cycles after RD entry.
- MNT=12'h363 with OUT_READY toggling every cycle → 9 elements with OUT_COL 0..2. Data stays stable during stalls. Only lanes 0–2 of words 0..2 are used.
- MNT=12'h066 → ERR=1, DONE 2 cycles after the START edge, EN_O never asserted, OUT_VALID never asserted.
- RSTN pulled low mid-EMIT of a 12'h888 run → all outputs 0 asynchronously. START held high after reset release does not restart; a fresh low-high edge runs cleanly.
- With `OUTRD_PAD_CHECK_EN`, MNT=12'h555 and a nonzero lane 1 in word 8 → PAD_ERR=1 after that word is read. The 25 streamed elements are unaffected.
